gamma_sequencer: RTL and testbench
==================================

# gamma_sequencer

Sequences one gamma cycle of a race-logic (temporal) datapath such as the greater-than and min/max comparator network. It accepts a binary time vector through a valid/ready handshake and issues the unit reset/gamma-reset pulses. It then drives one rising-edge spike line per input at the requested cycle and timestamps the first cycle the datapath result goes high. The binary result is returned through a valid/ready handshake. It sits between the host-side binary interface and the temporal compute units.

## Interface
- N_INPUTS, 2, number of spike lines driven into the datapath
- GAMMA_CYCLE_WIDTH, 16, RUN-phase length in aclk cycles (G); must be ≥2
- CLEAR_CYCLES, 1, length of the unit reset pulse; must be ≥1
- TW, $clog2(GAMMA_CYCLE_WIDTH)+1, time field width; value G encodes "null / never"
- aclk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  time vector offered
- in_ready  out  1  sequencer idle, accepts vector
- in_time  in  N_INPUTS×TW  spike time per input
- unit_rst  out  1  active-high reset to datapath SR latches
- unit_grst  out  1  active-high gamma reset to datapath counters
- spike  out  N_INPUTS  rising-edge encoded inputs to datapath
- result  in  1  datapath output line
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_time  out  TW  first cycle result was high, or G if never
- out_fired  out  1  result rose during RUN
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_time into time_q, go CLEAR, clear cnt.
- CLEAR: unit_rst=unit_grst=1, spike=0, result ignored. After CLEAR_CYCLES cycles go RUN with cnt=0.
- RUN: cnt counts 0..G-1. spike[i]=1 in every RUN cycle where cnt ≥ time_q[i]. time_q[i] ≥ G means spike[i] never rises. Spikes are monotonic within the cycle.
- Result capture: sample result at each RUN clock edge. On the first sample with result=1 and fired_q=0, set fired_q=1 and time_out=cnt. Later samples are ignored. The datapath is treated as combinational, so the result for spike-time k is sampled at cnt=k.
- End of RUN is the edge at cnt=G-1. Go DONE. If the result is never seen, time_out=G and fired=0.
- DONE: out_valid=1, spike=0, unit_rst=unit_grst=0. out_time and out_fired are held stable. On out_valid&&out_ready go IDLE.
- Width rules: cnt is TW bits and never wraps, because G-1 < 2^TW. Comparison is unsigned cnt ≥ time_q[i].

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, time_q=0, fired_q=0, time_out=0.
- Output values during and after reset: in_ready=1, busy=0, unit_rst=0, unit_grst=0, spike=0, out_valid=0, out_time=0, out_fired=0.
- Reset mid-operation in any state aborts the transaction immediately. No partial result is emitted.
- Latency: with the accept at edge 0, CLEAR occupies cycles 1..CLEAR_CYCLES. RUN is the next G cycles. out_valid is first high CLEAR_CYCLES+G+1 cycles after the accept edge, i.e. 18 for the defaults.
- All outputs are decoded from flops only. There is no combinational path from in_valid, out_ready or result to any output.
- in_valid during CLEAR/RUN/DONE is ignored (in_ready=0). in_time need only be stable at the accept edge.
- Back-to-back: after the DONE handshake edge, IDLE lasts at least one cycle before the next accept.
- result=1 during CLEAR, DONE or IDLE has no effect.
- time_q[i]=0: spike[i] is high in the first RUN cycle.

## Structure
- Shared package temporal_pkg holds:
  - gamma_state_t enum {IDLE, CLEAR, RUN, DONE}
  - function time_null(G), returning G
  - typedef for a TW-wide time field
- One sub-module, spike_encoder. Per input it takes cnt, time_q[i] and a run enable, and produces registered spike[i]. It is instantiated N_INPUTS times by generate.
- The FSM, the counter and the capture logic live in gamma_sequencer.

## Test plan
Defaults throughout: N_INPUTS=2, G=16, CLEAR_CYCLES=1.
- result=spike[0]&spike[1], in_time={3,7}: unit_rst/unit_grst high for 1 cycle, spike[0] rises at cnt=3, spike[1] rises at cnt=7. Then out_time=7, out_fired=1, out_valid exactly 18 cycles after the accept.
- result=spike[0]|spike[1], in_time={5,16}: spike[1] stays 0, out_time=5, out_fired=1.
- result=spike[0]|spike[1], in_time={16,16}: no spikes, out_time=16, out_fired=0.
- in_time={0,2} with the OR datapath: out_time=0. Hold out_ready=0 for 10 cycles: out_valid, out_time and out_fired stay stable, in_ready=0, spike=0. out_ready=1 gives IDLE one cycle later.
- Bench forces result=1 only during CLEAR and DONE, in_time={4,9} with the datapath otherwise silent: out_fired=0, out_time=16.
- rst_n pulsed low at cnt=4 of RUN: all outputs go to their reset values immediately and in_ready=1 after release. A following transaction {2,6} with the AND datapath returns out_time=6.

Source files
------------

// File: rtl/temporal_pkg.sv
// Shared types for the race-logic (temporal) datapath blocks.
package temporal_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} gamma_state_t;

  localparam int G_DEFAULT  = 16;
  localparam int TW_DEFAULT = $clog2(G_DEFAULT) + 1;

  typedef logic [TW_DEFAULT-1:0] time_t;

  // A spike time equal to the gamma cycle length means "never fires".
  function automatic int time_null(input int g);
    return g;
  endfunction
endpackage

// File: rtl/gamma_sequencer_spike_encoder.sv
// One rising-edge spike line; registered so the line is high in the RUN cycle whose cnt >= t.
module spike_encoder #(
  parameter int TW = 5
) (
  input  logic          aclk,
  input  logic          rst_n,
  input  logic          run_en,
  input  logic [TW-1:0] cnt,
  input  logic [TW-1:0] t,
  output logic          spike
);
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) spike <= 1'b0;
    else        spike <= run_en && (cnt >= t);
  end
endmodule

// File: rtl/gamma_sequencer.sv
// Sequences one gamma cycle: accept time vector, clear datapath, drive spikes, timestamp result.
module gamma_sequencer
  import temporal_pkg::*;
#(
  parameter int N_INPUTS          = 2,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int CLEAR_CYCLES      = 1,
  parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                   aclk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_INPUTS*TW-1:0] in_time,
  output logic                   unit_rst,
  output logic                   unit_grst,
  output logic [N_INPUTS-1:0]    spike,
  input  logic                   result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TW-1:0]          out_time,
  output logic                   out_fired,
  output logic                   busy
);
  localparam logic [TW-1:0] G_T      = TW'(time_null(GAMMA_CYCLE_WIDTH));
  localparam logic [TW-1:0] LAST     = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW-1:0] CLR_LAST = TW'(CLEAR_CYCLES - 1);

  gamma_state_t           state;
  logic [TW-1:0]          cnt;
  logic [N_INPUTS*TW-1:0] time_q;
  logic                   fired_q;
  logic [TW-1:0]          time_out;

  // Encoders register against the next-cycle count so spike is valid in the cycle it belongs to.
  logic          run_nxt;
  logic [TW-1:0] cnt_nxt;
  assign run_nxt = (state == CLEAR && cnt == CLR_LAST) || (state == RUN && cnt != LAST);
  assign cnt_nxt = (state == RUN) ? cnt + 1'b1 : '0;

  assign out_time  = time_out;
  assign out_fired = fired_q;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      time_q    <= '0;
      fired_q   <= 1'b0;
      time_out  <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      unit_rst  <= 1'b0;
      unit_grst <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          time_q    <= in_time;
          cnt       <= '0;
          fired_q   <= 1'b0;
          state     <= CLEAR;
          in_ready  <= 1'b0;
          busy      <= 1'b1;
          unit_rst  <= 1'b1;
          unit_grst <= 1'b1;
        end
        CLEAR: if (cnt == CLR_LAST) begin
          cnt       <= '0;
          state     <= RUN;
          unit_rst  <= 1'b0;
          unit_grst <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RUN: begin
          if (result && !fired_q) begin
            fired_q  <= 1'b1;
            time_out <= cnt;
          end
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (!result && !fired_q) time_out <= G_T;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_enc
    spike_encoder #(.TW(TW)) u_enc (
      .aclk   (aclk),
      .rst_n  (rst_n),
      .run_en (run_nxt),
      .cnt    (cnt_nxt),
      .t      (time_q[i*TW +: TW]),
      .spike  (spike[i])
    );
  end
endmodule

// File: tb/tb_gamma_sequencer.sv
// Directed bench for gamma_sequencer with a behavioural AND/OR datapath on the result line.
module tb_gamma_sequencer;
  localparam int TW = 5;

  logic          aclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2*TW-1:0] in_time = '0;
  logic          unit_rst, unit_grst;
  logic [1:0]    spike;
  logic          result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_time;
  logic          out_fired;
  logic          busy;

  int mode = 0; // 0 AND, 1 OR, 2 silent, 3 forced high in CLEAR/DONE
  int n_chk = 0;
  int n_fail = 0;
  int s0, s1, ov, rc;

  assign result = (mode == 0) ? &spike :
                  (mode == 1) ? |spike :
                  (mode == 3) ? (unit_rst | out_valid) : 1'b0;

  always #5 aclk = ~aclk;

  gamma_sequencer dut (
    .aclk(aclk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_time(in_time), .unit_rst(unit_rst), .unit_grst(unit_grst), .spike(spike),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .out_time(out_time), .out_fired(out_fired), .busy(busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_unit_rst"}, int'({unit_rst, unit_grst}), 0);
    chk({tag, "_spike"}, int'(spike), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_time"}, int'(out_time), 0);
    chk({tag, "_out_fired"}, int'(out_fired), 0);
  endtask

  // Accept a vector, then record (in cycles after the accept edge) spike rises and out_valid.
  task automatic run_txn(input logic [TW-1:0] t0, input logic [TW-1:0] t1);
    @(negedge aclk);
    chk("in_ready_pre", int'(in_ready), 1);
    in_time  = {t1, t0};
    in_valid = 1'b1;
    @(posedge aclk);
    #1 in_valid = 1'b0;
    in_time = '0;
    s0 = -1; s1 = -1; ov = -1; rc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge aclk);
      if (unit_rst && unit_grst) rc++;
      if (spike[0] && s0 < 0) s0 = c;
      if (spike[1] && s1 < 0) s1 = c;
      if (out_valid) begin ov = c; break; end
    end
  endtask

  task automatic finish_txn(input string tag);
    @(negedge aclk);
    out_ready = 1'b1;
    @(posedge aclk);
    #1 out_ready = 1'b0;
    @(negedge aclk);
    chk({tag, "_idle_out_valid"}, int'(out_valid), 0);
    chk({tag, "_idle_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    bit stable;
    #12;
    chk_reset_outs("reset");
    @(negedge aclk);
    rst_n = 1'b1;

    // AND, {3,7}: spikes at cnt 3/7 -> cycles 5/9, result at cnt 7, out_valid at cycle 18
    mode = 0;
    run_txn(5'd3, 5'd7);
    chk("and_rst_cycles", rc, 1);
    chk("and_s0_rise", s0, 5);
    chk("and_s1_rise", s1, 9);
    chk("and_latency", ov, 18);
    chk("and_out_time", int'(out_time), 7);
    chk("and_out_fired", int'(out_fired), 1);
    chk("and_done_spike", int'(spike), 0);
    finish_txn("and");

    // OR, {5,16}: spike[1] never rises
    mode = 1;
    run_txn(5'd5, 5'd16);
    chk("or_s1_never", s1, -1);
    chk("or_out_time", int'(out_time), 5);
    chk("or_out_fired", int'(out_fired), 1);
    finish_txn("or");

    // OR, {16,16}: nothing fires
    run_txn(5'd16, 5'd16);
    chk("null_s0", s0, -1);
    chk("null_out_time", int'(out_time), 16);
    chk("null_out_fired", int'(out_fired), 0);
    finish_txn("null");

    // OR, {0,2}: first RUN cycle fires; hold out_ready low
    run_txn(5'd0, 5'd2);
    chk("zero_s0_rise", s0, 2);
    chk("zero_out_time", int'(out_time), 0);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      if (!(out_valid === 1'b1 && out_time === 5'd0 && out_fired === 1'b1 &&
            in_ready === 1'b0 && spike === 2'b00)) stable = 1'b0;
    end
    chk("hold_stable", int'(stable), 1);
    finish_txn("hold");

    // Result forced high only in CLEAR and DONE
    mode = 3;
    run_txn(5'd4, 5'd9);
    chk("forced_out_fired", int'(out_fired), 0);
    chk("forced_out_time", int'(out_time), 16);
    chk("forced_latency", ov, 18);
    finish_txn("forced");

    // Reset at cnt=4 of RUN (cycle 6), then a clean AND transaction
    mode = 2;
    @(negedge aclk);
    in_time  = {5'd9, 5'd4};
    in_valid = 1'b1;
    @(posedge aclk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge aclk);
    chk("pre_rst_spike0", int'(spike[0]), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge aclk);
    rst_n = 1'b1;
    @(negedge aclk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    mode = 0;
    run_txn(5'd2, 5'd6);
    chk("after_rst_out_time", int'(out_time), 6);
    chk("after_rst_out_fired", int'(out_fired), 1);
    chk("after_rst_latency", ov, 18);
    finish_txn("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
